alu_issue_stage: RTL and testbench

Drives the combinational ALU's operand and control inputs from incoming instructions, then consumes the ALU's Zero and result outputs. It decodes RV32I instructions into the ALU control encoding, registers the decoded operation in an execute (E) stage, and applies ALU_in1, ALU_in2 and ALU_ctrl from that register. It captures ALU_out/Zero, plus the branch and jump outcome, into an output (O) register. Valid/ready handshakes sit on both sides, between the register-read stage and writeback/PC logic.

---
 rtl/alu_issue_stage.sv | 203 ++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I into ALU controls in an E register, captures ALU result plus branch/jump outcome in an O register.
module alu_issue_stage #(
    parameter bit RESET_PC_ZERO = 1'b1,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic [XLEN-1:0] ALU_in1,
    output logic [XLEN-1:0] ALU_in2,
    output logic [3:0]      ALU_ctrl,
    input  logic [XLEN-1:0] ALU_out,
    input  logic            Zero,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_is_mem,
    output logic            out_br_taken,
    output logic [XLEN-1:0] out_br_target,
    output logic            out_illegal
);
    localparam logic [XLEN-1:0] RST_VAL = {XLEN{!RESET_PC_ZERO}};

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [3:0]      ctrl;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [2:0]      f3;
        logic            we;
        logic            mem;
        logic            br;
        logic            jal;
        logic            jalr;
        logic            ill;
    } e_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] result;
        logic [4:0]      rd;
        logic            rd_we;
        logic            is_mem;
        logic            br_taken;
        logic [XLEN-1:0] br_target;
        logic            illegal;
    } o_t;

    e_t e_q, e_d;
    o_t o_q, o_d;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] d_in1, d_in2, d_imm;
    logic [3:0] d_ctrl;
    logic d_we, d_mem, d_br, d_jal, d_jalr, d_ill;
    logic advance, accept, link;

    assign opc   = in_instr[6:0];
    assign rd    = in_instr[11:7];
    assign f3    = in_instr[14:12];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u = {in_instr[31:12], 12'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    always_comb begin
        d_in1  = in_rs1_data;
        d_in2  = in_rs2_data;
        d_ctrl = 4'b0000;
        d_imm  = imm_b;
        d_we   = 1'b0;
        d_mem  = 1'b0;
        d_br   = 1'b0;
        d_jal  = 1'b0;
        d_jalr = 1'b0;
        d_ill  = 1'b0;
        case (opc)
            7'b0110011: begin
                d_ctrl = {in_instr[30], f3};
                d_we   = 1'b1;
                d_ill  = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            7'b0010011: begin
                d_in2  = imm_i;
                d_ctrl = {f3 == 3'b101 && in_instr[30], f3};
                d_we   = 1'b1;
                d_ill  = (f3 == 3'b001 && f7 != 7'h00) || (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'b0110111: begin
                d_in1 = '0;
                d_in2 = imm_u;
                d_we  = 1'b1;
            end
            7'b0010111: begin
                d_in1 = in_pc;
                d_in2 = imm_u;
                d_we  = 1'b1;
            end
            7'b0000011: begin
                d_in2 = imm_i;
                d_mem = 1'b1;
            end
            7'b0100011: begin
                d_in2 = imm_s;
                d_mem = 1'b1;
            end
            7'b1100111: begin
                d_in2  = imm_i;
                d_we   = 1'b1;
                d_jalr = 1'b1;
            end
            7'b1101111: begin
                d_in1 = '0;
                d_in2 = '0;
                d_imm = imm_j;
                d_we  = 1'b1;
                d_jal = 1'b1;
            end
            7'b1100011: begin
                d_br   = 1'b1;
                d_ctrl = f3[2] ? {3'b001, f3[1]} : 4'b1000;
                d_ill  = f3[2:1] == 2'b01;
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_ctrl = 4'b0000;
            d_we   = 1'b0;
            d_mem  = 1'b0;
            d_br   = 1'b0;
            d_jal  = 1'b0;
            d_jalr = 1'b0;
        end
        d_we = d_we && rd != 5'd0;
    end

    assign advance  = !o_q.valid || out_ready;
    assign in_ready = rst_n && !flush && (!e_q.valid || advance);
    assign accept   = in_valid && in_ready;

    always_comb begin
        e_d = e_q;
        if (accept)
            e_d = '{valid: 1'b1, in1: d_in1, in2: d_in2, ctrl: d_ctrl, pc: in_pc, imm: d_imm, rd: rd, f3: f3,
                    we: d_we, mem: d_mem, br: d_br, jal: d_jal, jalr: d_jalr, ill: d_ill};
        else if (advance || flush)
            e_d.valid = 1'b0;
    end

    // Links return pc+4; JAL and branches use their own target adder, JALR takes the ALU sum.
    assign link = e_q.jal || e_q.jalr;

    always_comb begin
        o_d.valid     = e_q.valid;
        o_d.result    = link ? e_q.pc + 4 : ALU_out;
        o_d.rd        = e_q.rd;
        o_d.rd_we     = e_q.we;
        o_d.is_mem    = e_q.mem;
        o_d.br_taken  = link || (e_q.br && ((e_q.f3[2] ? ALU_out[0] : Zero) ^ e_q.f3[0]));
        o_d.br_target = e_q.jalr ? {ALU_out[XLEN-1:1], 1'b0} : e_q.pc + e_q.imm;
        o_d.illegal   = e_q.ill;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= '0;
            o_q <= '0;
            o_q.br_target <= RST_VAL;
        end else begin
            e_q <= e_d;
            if (advance)
                o_q <= o_d;
        end
    end

    assign ALU_in1       = e_q.in1;
    assign ALU_in2       = e_q.in2;
    assign ALU_ctrl      = e_q.ctrl;
    assign out_valid     = o_q.valid;
    assign out_result    = o_q.result;
    assign out_rd        = o_q.rd;
    assign out_rd_we     = o_q.rd_we;
    assign out_is_mem    = o_q.is_mem;
    assign out_br_taken  = o_q.br_taken;
    assign out_br_target = o_q.br_target;
    assign out_illegal   = o_q.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed checks of decode, ALU hookup, handshakes, flush and async reset.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        flush = 1'b0;
    logic [31:0] ALU_in1, ALU_in2, ALU_out;
    logic [3:0]  ALU_ctrl;
    logic        Zero;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result, out_br_target;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_is_mem, out_br_taken, out_illegal;
    int checks = 0;
    int failures = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .flush(flush),
        .ALU_in1(ALU_in1), .ALU_in2(ALU_in2), .ALU_ctrl(ALU_ctrl), .ALU_out(ALU_out), .Zero(Zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_rd_we(out_rd_we), .out_is_mem(out_is_mem), .out_br_taken(out_br_taken),
        .out_br_target(out_br_target), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference combinational ALU driven by the stage.
    always_comb begin
        case (ALU_ctrl)
            4'b0000: ALU_out = ALU_in1 + ALU_in2;
            4'b1000: ALU_out = ALU_in1 - ALU_in2;
            4'b0001: ALU_out = ALU_in1 << ALU_in2[4:0];
            4'b0010: ALU_out = {31'b0, $signed(ALU_in1) < $signed(ALU_in2)};
            4'b0011: ALU_out = {31'b0, ALU_in1 < ALU_in2};
            4'b0100: ALU_out = ALU_in1 ^ ALU_in2;
            4'b0101: ALU_out = ALU_in1 >> ALU_in2[4:0];
            4'b1101: ALU_out = $signed(ALU_in1) >>> ALU_in2[4:0];
            4'b0110: ALU_out = ALU_in1 | ALU_in2;
            4'b0111: ALU_out = ALU_in1 & ALU_in2;
            default: ALU_out = '0;
        endcase
        Zero = ALU_out == '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc = pc;
        in_rs1_data = a;
        in_rs2_data = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ctrl", ALU_ctrl, 0);
        chk("rst_in1", ALU_in1, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", out_result, 0);
        chk("rst_target", out_br_target, 0);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", in_ready, 1);

        issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
        chk("add_ctrl", ALU_ctrl, 4'b0000);
        chk("add_in1", ALU_in1, 5);
        chk("add_o_not_yet", out_valid, 0);
        @(negedge clk);
        chk("add_valid", out_valid, 1);
        chk("add_result", out_result, 12);
        chk("add_rd", out_rd, 3);
        chk("add_we", out_rd_we, 1);

        issue(32'h40435293, 32'h0, 32'h80000000, 32'h0);
        chk("srai_ctrl", ALU_ctrl, 4'b1101);
        @(negedge clk);
        chk("srai_result", out_result, 32'hF8000000);
        chk("srai_rd", out_rd, 5);

        issue(32'h402083B3, 32'h0, 32'd3, 32'd5);
        chk("sub_ctrl", ALU_ctrl, 4'b1000);
        @(negedge clk);
        chk("sub_result", out_result, 32'hFFFFFFFE);

        issue(32'h02208063, 32'h100, 32'd9, 32'd9);
        chk("beq_ctrl", ALU_ctrl, 4'b1000);
        @(negedge clk);
        chk("beq_taken", out_br_taken, 1);
        chk("beq_target", out_br_target, 32'h120);
        chk("beq_we", out_rd_we, 0);

        issue(32'h0220E063, 32'h100, 32'hFFFFFFFF, 32'd1);
        chk("bltu_ctrl", ALU_ctrl, 4'b0011);
        @(negedge clk);
        chk("bltu_taken", out_br_taken, 0);

        issue(32'h0080A203, 32'h0, 32'h1000, 32'h0);
        @(negedge clk);
        chk("lw_addr", out_result, 32'h1008);
        chk("lw_mem", out_is_mem, 1);
        chk("lw_we", out_rd_we, 0);

        issue(32'h00108013, 32'h0, 32'd4, 32'h0);
        @(negedge clk);
        chk("x0_result", out_result, 5);
        chk("x0_we", out_rd_we, 0);

        issue(32'h008000EF, 32'h200, 32'h0, 32'h0);
        @(negedge clk);
        chk("jal_result", out_result, 32'h204);
        chk("jal_target", out_br_target, 32'h208);
        chk("jal_taken", out_br_taken, 1);
        chk("jal_we", out_rd_we, 1);

        issue(32'h0000037F, 32'h0, 32'd1, 32'd2);
        chk("ill_op_ctrl", ALU_ctrl, 0);
        @(negedge clk);
        chk("ill_op", out_illegal, 1);
        chk("ill_op_we", out_rd_we, 0);
        chk("ill_op_taken", out_br_taken, 0);
        chk("ill_op_mem", out_is_mem, 0);

        issue(32'h022081B3, 32'h0, 32'd3, 32'd4);
        @(negedge clk);
        chk("ill_f7", out_illegal, 1);
        chk("ill_f7_we", out_rd_we, 0);

        in_valid = 1'b1;
        in_instr = 32'h00100513;
        in_rs1_data = '0;
        @(negedge clk);
        in_instr = 32'h00200593;
        out_ready = 1'b0;
        #1 chk("strm_ready_empty_o", in_ready, 1);
        @(negedge clk);
        chk("strm_o_a_valid", out_valid, 1);
        chk("strm_o_a", out_result, 1);
        chk("strm_o_a_rd", out_rd, 10);
        in_instr = 32'h00300613;
        #1 chk("strm_ready_full", in_ready, 0);
        @(negedge clk);
        chk("strm_hold1", out_result, 1);
        chk("strm_hold1_rd", out_rd, 10);
        chk("strm_e_b", ALU_in2, 2);
        @(negedge clk);
        chk("strm_hold2", out_result, 1);
        chk("strm_hold2_valid", out_valid, 1);
        out_ready = 1'b1;
        #1 chk("strm_ready_release", in_ready, 1);
        @(negedge clk);
        chk("strm_o_b", out_result, 2);
        chk("strm_o_b_rd", out_rd, 11);
        in_valid = 1'b0;
        @(negedge clk);
        chk("strm_o_c", out_result, 3);
        chk("strm_o_c_rd", out_rd, 12);
        @(negedge clk);
        chk("strm_drained", out_valid, 0);

        in_valid = 1'b1;
        in_instr = 32'h00700693;
        @(negedge clk);
        in_instr = 32'h00900713;
        out_ready = 1'b0;
        @(negedge clk);
        chk("fl_o_w", out_result, 7);
        flush = 1'b1;
        in_instr = 32'h00B00793;
        #1 chk("fl_ready", in_ready, 0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_o_kept", out_result, 7);
        chk("fl_o_kept_rd", out_rd, 13);
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_e_killed", out_valid, 0);
        @(negedge clk);
        chk("fl_nothing_more", out_valid, 0);

        in_valid = 1'b1;
        in_instr = 32'h00100513;
        @(negedge clk);
        in_instr = 32'h00200593;
        @(negedge clk);
        chk("mid_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", out_valid, 0);
        chk("mid_result", out_result, 0);
        chk("mid_rd", out_rd, 0);
        chk("mid_in2", ALU_in2, 0);
        chk("mid_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
